inst_fetch_queue: RTL

//  Parametrised instruction-fetch stage: keeps one instruction memory read in flight per

---
 rtl/inst_fetch_queue_if.sv | 25 ++
 rtl/inst_fetch_queue.sv | 109 ++++++++++
 2 files changed

// File: rtl/inst_fetch_queue_if.sv
// Decode-side handshake of the instruction fetch queue.
// The fetch queue is the master; decode is the slave.
interface inst_fetch_queue_if #(
    parameter int PC_W   = 16,
    parameter int INST_W = 16
);
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [PC_W-1:0]   out_pc;

    modport master (
        output out_valid,
        output out_inst,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_inst,
        input  out_pc,
        output out_ready
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: one RAM read in flight per cycle,
// returned (pc, inst) pairs buffered in a DEPTH-entry FIFO for decode.
module inst_fetch_queue #(
    parameter int              PC_W     = 16,
    parameter int              INST_W   = 16,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   redirect,
    input  logic [PC_W-1:0]        redirect_pc,
    input  logic                   halt,
    output logic [PC_W-1:0]        imem_addr,
    output logic                   imem_rd,
    input  logic [INST_W-1:0]      imem_q,
    inst_fetch_queue_if.master     dec,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    typedef enum logic {WAKE, RUN} state_e;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    state_e          state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic            infl_q;
    logic [PC_W-1:0] infl_pc_q;
    logic [AW-1:0]   rd_q, wr_q;
    logic [CW-1:0]   cnt_q;
    entry_t          mem_q [DEPTH];

    logic            run;
    logic            credit;
    logic            push;
    logic            pop;
    logic            out_vld;
    logic [CW:0]     used;

    // A read is only issued if its return is guaranteed a free slot.
    assign used    = {1'b0, cnt_q} + {{CW{1'b0}}, infl_q};
    assign credit  = used < DEPTH_C;
    assign out_vld = (cnt_q != '0) & ~redirect & (state_q == RUN);
    assign push    = infl_q & ~redirect;
    assign pop     = out_vld & dec.out_ready;

    assign dec.out_valid = out_vld;
    assign dec.out_inst  = mem_q[rd_q].inst;
    assign dec.out_pc    = mem_q[rd_q].pc;
    assign occupancy     = cnt_q;

    always_comb begin
        state_d    = state_q;
        run        = 1'b0;
        imem_rd    = 1'b0;
        imem_addr  = fetch_pc_q;
        fetch_pc_d = fetch_pc_q;
        unique case (state_q)
            WAKE: state_d = RUN;
            RUN:  run     = 1'b1;
        endcase
        if (redirect) begin
            state_d    = RUN;
            imem_rd    = 1'b1;
            imem_addr  = redirect_pc;
            fetch_pc_d = redirect_pc + PC_W'(1);
        end else if (run && !halt && credit) begin
            imem_rd    = 1'b1;
            fetch_pc_d = fetch_pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAKE;
            fetch_pc_q <= RESET_PC;
            infl_q     <= 1'b0;
            infl_pc_q  <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            infl_q     <= imem_rd;
            infl_pc_q  <= imem_addr;
            if (redirect) begin
                rd_q  <= '0;
                wr_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (push) wr_q <= wr_q + AW'(1);
                if (pop)  rd_q <= rd_q + AW'(1);
                cnt_q <= cnt_q + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage carries no reset; contents are only observed when counted valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= '{pc: infl_pc_q, inst: imem_q};
    end
endmodule
